// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Purely combinational 4-bit ripple-carry adder used as the shared datapath.
module binary_adder_4_bit
   import nibble_serial_adder_ctrl_pkg::*;
(
   output logic [NIBBLE_W-1:0] S,
   output logic                Cout,
   input  logic [NIBBLE_W-1:0] A,
   input  logic [NIBBLE_W-1:0] B,
   input  logic                Cin
);

   logic carry;

   always_comb begin
      carry = Cin;
      S     = '0;
      for (int i = 0; i < NIBBLE_W; i++) begin
         S[i]  = A[i] ^ B[i] ^ carry;
         carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
      end
      Cout = carry;
   end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer adding two W-bit operands one nibble per clock, LSB first,
// on a single shared 4-bit adder with the carry kept in c_reg.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [4*NIBBLES-1:0]    a,
   input  logic [4*NIBBLES-1:0]    b,
   input  logic                    cin,
   output logic                    ready,
   output logic                    busy,
   output logic                    done,
   output logic [4*NIBBLES-1:0]    sum,
   output logic                    cout,
   output logic                    ovf
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int CNT_W = $clog2(NIBBLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

   state_t              state;
   logic [W-1:0]        a_sh;
   logic [W-1:0]        b_sh;
   logic [W-1:0]        sum_sh;
   logic                c_reg;
   logic [CNT_W-1:0]    cnt;
   logic                sa;
   logic                sb;

   logic [NIBBLE_W-1:0] s_nib;
   logic                c_nib;
   logic [W+3:0]        sum_cat;
   logic [W-1:0]        sum_sh_next;

   binary_adder_4_bit u_adder (
      .S    (s_nib),
      .Cout (c_nib),
      .A    (a_sh[NIBBLE_W-1:0]),
      .B    (b_sh[NIBBLE_W-1:0]),
      .Cin  (c_reg)
   );

   // New nibble enters at the top so after NIBBLES shifts nibble 0 sits at the bottom.
   assign sum_cat     = {s_nib, sum_sh};
   assign sum_sh_next = sum_cat[W+3:4];

   assign ready = (state == ST_IDLE);
   assign busy  = (state == ST_RUN) || (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c_reg  <= 1'b0;
         cnt    <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c_reg <= cin;
                  cnt   <= '0;
                  sa    <= a[W-1];
                  sb    <= b[W-1];
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_sh <= sum_sh_next;
               a_sh   <= a_sh >> NIBBLE_W;
               b_sh   <= b_sh >> NIBBLE_W;
               c_reg  <= c_nib;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  // Results are loaded from the final nibble so they are valid with done.
                  sum   <= sum_sh_next;
                  cout  <= c_nib;
                  ovf   <= (sa == sb) && (s_nib[NIBBLE_W-1] != sa);
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
